fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

Round-robin arbiter that shares one first-word-fall-through FIFO among N upstream requesters, each a valid/ready stream with a packet-end marker. Each accepted beat is tagged with its source index, optionally with the grant held for a whole packet, and written into an internal `fifo_wrapper`. The downstream consumer drains the FIFO through a plain valid/ready port. It sits between parallel producers (e.g. per-region decoder outputs) and a single shared result channel.

## Interface
Parameters:
- `N`, 4: number of requesters, ≥2.
- `WIDTH`, 4: payload bits per beat.
- `DEPTH`, 16: internal FIFO depth, power of 2; usable capacity is DEPTH-1 entries.
- `LOCK_PACKETS`, 1: 1 = grant held from first beat until the `last` beat; 0 = re-arbitrate every beat.

Ports:
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  N  per-requester beat valid.
- `in_ready`  out  N  per-requester beat accept; at most one bit set.
- `in_data`  in  N*WIDTH  requester i's payload in bits [i*WIDTH +: WIDTH].
- `in_last`  in  N  per-requester packet-end marker.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  consumer pops head when high with `out_valid`.
- `out_data`  out  WIDTH  head payload.
- `out_last`  out  1  head packet-end marker.
- `out_src`  out  SW  head source index, SW = $clog2(N).

## Operation
- FIFO entry is {src, last, data}, width SW+1+WIDTH.
- State `st` ∈ {IDLE, LOCKED}; registers `ptr` (round-robin start, SW bits) and `owner` (SW bits).
- IDLE grant: first i with `in_valid[i]`=1, scanning ptr, ptr+1, …, ptr+N-1 mod N. No valid requester means no grant.
- LOCKED grant: `owner`, whether or not `in_valid[owner]` is high. Other requesters are never granted.
- `in_ready[i]` = (grant==i) && !fifo_full. It is combinational from `in_valid`, `st`, `ptr`, `owner` and full.
- Transfer = `in_valid[g] && in_ready[g]`. It writes {g, in_last[g], in_data[g]} into the FIFO the same edge.
- On a transfer with `in_last`=1, or with LOCK_PACKETS=0:
  - `st`→IDLE;
  - `ptr`←g+1 mod N (wraps N-1→0).
- On a transfer with `in_last`=0 and LOCK_PACKETS=1:
  - `st`→LOCKED;
  - `owner`←g;
  - `ptr` unchanged.
- No transfer leaves all state unchanged. A requester dropping valid while LOCKED stalls the arbiter. It does not release it.
- `ptr` is never changed by a grant that is not accepted because the FIFO is full.
- FIFO full: every `in_ready` is 0 and the grant decision is still computed. Arbitration is not stalled by `out_ready`, except through full.
- FIFO empty: `out_valid`=0; `out_data`/`out_last`/`out_src` are don't-care.
- Simultaneous push and pop on a full FIFO: the push is rejected, because full is evaluated before the pop.
- Reset is asynchronous, active low. It forces `st`=IDLE, `ptr`=0, `owner`=0.
  - The FIFO is cleared by driving its synchronous reset with ~`reset`, held for the whole assertion.
  - While `reset`=0: `in_ready`=0 and `out_valid`=0.
  - Reset mid-packet discards all buffered and partial packets. There is no recovery of lost beats.

## Timing
- A transfer at edge t makes the beat visible at the FIFO head after edge t, i.e. `out_valid`=1 in cycle t+1 when the FIFO was empty. Latency is 1 cycle.
- Throughput is one beat per cycle sustained while the FIFO is not full and the consumer pops every cycle.
- Switching between requesters costs no bubble cycle: the beat after a `last` can come from a different source on the next edge.
- Fill: with `out_ready`=0, the FIFO accepts 15 beats (DEPTH=16). `in_ready` is 0 from the cycle after the 15th push.
- Reset release: the first transfer is possible in the first cycle with `reset`=1, with `ptr`=0 giving requester 0 priority.

## Structure
- Shared package holds:
  - `fifo_rr_src_width(N)`, i.e. $clog2(N);
  - the entry packing order {src, last, data};
  - the IDLE/LOCKED state encoding.
- One sub-module instance: `fifo_wrapper` (DEPTH, WIDTH=SW+1+WIDTH).
  - Drive `input_valid` with the transfer condition, not raw valid.
  - `input_ready` drives !fifo_full.
- The grant scan is a rotate-and-priority-encode function in the same file. It has no separate module.

## Test plan
- Reset mid-traffic: assert `reset`=0 while LOCKED with 5 entries buffered.
  - Asynchronously: `in_ready`=0 and `out_valid`=0.
  - After release: `ptr`=0, FIFO empty, the next grant goes to the lowest valid index.
- All N=4 valid, single-beat packets (`in_last`=1), `out_ready`=1 → accepted source order 0,1,2,3,0,1…, one per cycle. `out_src` follows the same order one cycle later.
- Packet lock, LOCK_PACKETS=1:
  - Stimulus: requester 2 sends 3 beats (last on beat 3) while requesters 0 and 3 are valid.
  - Required: `out_src`=2,2,2 then 3. Requester 0 waits until after 3.
  - Requester 2 dropping valid for 2 cycles mid-packet → no other grant during the gap.
- Full boundary, DEPTH=16, `out_ready`=0:
  - Exactly 15 beats accepted, then `in_ready`=0.
  - One pop → exactly one more beat accepted. `ptr` is unaffected by stalled grants.
- LOCK_PACKETS=0, requesters 1 and 3 both sending `in_last`=0 streams → beats interleave 1,3,1,3. `out_last`=0 is preserved per beat.
- Wrap-around: only requester 3 valid, then requesters 3 and 0 valid → the grant goes to 0 next (ptr wraps 3→0), then 3.

Source files
------------

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared definitions for the round-robin FIFO arbiter: state encoding and entry layout.
// Entry layout is {src, last, data}, with data in the low WIDTH bits.
package fifo_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  function automatic int fifo_rr_src_width(input int n);
    return $clog2(n);
  endfunction

  function automatic int fifo_rr_entry_width(input int n, input int w);
    return fifo_rr_src_width(n) + 1 + w;
  endfunction

endpackage

// File: rtl/fifo_wrapper.sv
// First-word-fall-through FIFO with synchronous reset; holds DEPTH-1 entries so that
// full and empty are distinguishable from the pointers alone.
module fifo_wrapper #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [WIDTH-1:0] input_data,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [WIDTH-1:0] output_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (AW'(r_wr_ptr + 1'b1) == r_rd_ptr);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = input_valid && !w_full;
  assign w_pop   = output_ready && !w_empty;

  assign input_ready  = !w_full;
  assign output_valid = !w_empty;
  // Head is read straight from the array so a beat is visible the cycle after its push.
  assign output_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= AW'(r_wr_ptr + 1'b1);
      if (w_pop)  r_rd_ptr <= AW'(r_rd_ptr + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= input_data;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin arbiter merging N valid/ready packet streams into one shared FIFO,
// tagging each beat with its source index and optionally locking the grant per packet.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int N            = 4,
  parameter int WIDTH        = 4,
  parameter int DEPTH        = 16,
  parameter int LOCK_PACKETS = 1,
  localparam int SW          = fifo_rr_src_width(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SW-1:0]        out_src
);

  localparam int EW = fifo_rr_entry_width(N, WIDTH);

  // Returns {found, index}: first valid requester scanning start, start+1, ... mod N.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] valid, input logic [SW-1:0] start);
    logic [SW:0]   res;
    logic [SW-1:0] cand;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = SW'((int'(start) + k) % N);
      if (valid[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  arb_state_t       r_st;
  arb_state_t       w_st_next;
  logic [SW-1:0]    r_ptr;
  logic [SW-1:0]    w_ptr_next;
  logic [SW-1:0]    r_owner;
  logic [SW-1:0]    w_owner_next;

  logic [SW:0]      w_pick;
  logic             w_grant_vld;
  logic [SW-1:0]    w_grant;
  logic [SW-1:0]    w_grant_inc;
  logic             w_fifo_ready;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data_arr [N];
  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_last;
  logic [EW-1:0]    w_entry;
  logic             w_fifo_out_valid;
  logic [EW-1:0]    w_head;

  assign w_pick = rr_pick(in_valid, r_ptr);

  always_comb begin
    w_grant_vld = w_pick[SW];
    w_grant     = w_pick[SW-1:0];
    if (r_st == ST_LOCKED) begin
      w_grant_vld = 1'b1;
      w_grant     = r_owner;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign w_data_arr[gi] = in_data[gi*WIDTH +: WIDTH];
      assign in_ready[gi]   = reset && w_grant_vld && (w_grant == SW'(gi)) && w_fifo_ready;
    end
  endgenerate

  assign w_sel_data  = w_data_arr[w_grant];
  assign w_sel_last  = in_last[w_grant];
  assign w_entry     = {w_grant, w_sel_last, w_sel_data};
  assign w_xfer      = reset && w_grant_vld && in_valid[w_grant] && w_fifo_ready;
  assign w_grant_inc = (w_grant == SW'(N - 1)) ? '0 : SW'(w_grant + 1'b1);

  always_comb begin
    w_st_next    = r_st;
    w_ptr_next   = r_ptr;
    w_owner_next = r_owner;
    if (w_xfer) begin
      if (w_sel_last || (LOCK_PACKETS == 0)) begin
        w_st_next  = ST_IDLE;
        w_ptr_next = w_grant_inc;
      end else begin
        w_st_next    = ST_LOCKED;
        w_owner_next = w_grant;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st    <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_st    <= w_st_next;
      r_ptr   <= w_ptr_next;
      r_owner <= w_owner_next;
    end
  end

  // The FIFO's synchronous clear is held for as long as the asynchronous reset is asserted.
  fifo_wrapper #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk          (clk),
    .srst         (~reset),
    .input_valid  (w_xfer),
    .input_ready  (w_fifo_ready),
    .input_data   (w_entry),
    .output_valid (w_fifo_out_valid),
    .output_ready (out_ready),
    .output_data  (w_head)
  );

  assign out_valid = reset && w_fifo_out_valid;
  assign out_src   = w_head[EW-1 -: SW];
  assign out_last  = w_head[WIDTH];
  assign out_data  = w_head[WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: packet-locked instance plus a per-beat instance.
module tb_fifo_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic [3:0]  in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [3:0]  out_data;
  logic [1:0]  out_src;

  logic [3:0]  nl_in_valid, nl_in_ready, nl_in_last;
  logic [15:0] nl_in_data;
  logic        nl_out_valid, nl_out_ready, nl_out_last;
  logic [3:0]  nl_out_data;
  logic [1:0]  nl_out_src;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.N(4), .WIDTH(4), .DEPTH(16), .LOCK_PACKETS(1)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src)
  );

  fifo_rr_arbiter #(.N(4), .WIDTH(4), .DEPTH(16), .LOCK_PACKETS(0)) u_dut_nl (
    .clk(clk), .reset(reset),
    .in_valid(nl_in_valid), .in_ready(nl_in_ready), .in_data(nl_in_data), .in_last(nl_in_last),
    .out_valid(nl_out_valid), .out_ready(nl_out_ready), .out_data(nl_out_data),
    .out_last(nl_out_last), .out_src(nl_out_src)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One cycle on the locked instance: drive, check combinational/head outputs, advance.
  task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic ordy,
                     input logic [3:0] e_rdy, input logic e_ov, input logic [1:0] e_src,
                     input string tag);
    logic [3:0] e_data;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    #1;
    chk({tag, ".rdy"}, 32'(in_ready), 32'(e_rdy));
    chk({tag, ".ov"},  32'(out_valid), 32'(e_ov));
    if (e_ov) begin
      e_data = 4'hA + {2'b00, e_src};
      chk({tag, ".src"},  32'(out_src), 32'(e_src));
      chk({tag, ".data"}, 32'(out_data), 32'(e_data));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    in_valid     = 4'hF;
    in_last      = 4'hF;
    in_data      = 16'hDCBA;
    out_ready    = 1'b1;
    nl_in_valid  = 4'b1010;
    nl_in_last   = 4'b0000;
    nl_in_data   = 16'h3210;
    nl_out_ready = 1'b1;

    #2;
    chk("rst.in_ready",    32'(in_ready), 32'(0));
    chk("rst.out_valid",   32'(out_valid), 32'(0));
    chk("rst.nl_in_ready", 32'(nl_in_ready), 32'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst.out_valid2", 32'(out_valid), 32'(0));
    in_valid = 4'h0;
    reset    = 1'b1;

    // Per-beat arbitration: requesters 1 and 3 alternate, last stays 0.
    for (int k = 0; k < 6; k++) begin
      nl_in_valid = 4'b1010;
      #1;
      chk("nl.rdy", 32'(nl_in_ready), (k % 2 == 0) ? 32'h2 : 32'h8);
      if (k > 0) begin
        chk("nl.ov",   32'(nl_out_valid), 32'(1));
        chk("nl.src",  32'(nl_out_src), (k % 2 == 1) ? 32'h1 : 32'h3);
        chk("nl.data", 32'(nl_out_data), (k % 2 == 1) ? 32'h1 : 32'h3);
        chk("nl.last", 32'(nl_out_last), 32'(0));
      end
      @(posedge clk);
      #1;
    end
    nl_in_valid = 4'b0000;
    #1;
    chk("nl.end_src", 32'(nl_out_src), 32'h3);
    @(posedge clk);
    #1;
    chk("nl.drained", 32'(nl_out_valid), 32'(0));

    // All requesters valid with single-beat packets.
    for (int k = 0; k < 8; k++)
      cyc(4'hF, 4'hF, 1'b1, 4'(1 << (k % 4)), k > 0, 2'((k + 3) % 4), "rr");
    cyc(4'h0, 4'h0, 1'b1, 4'h0, 1'b1, 2'd3, "rr_end");
    cyc(4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, "rr_idle");

    // Packet lock on requester 2 with a two-cycle valid gap.
    cyc(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, "lk_pre");
    cyc(4'b1101, 4'b1001, 1'b1, 4'b0100, 1'b1, 2'd1, "lk_b1");
    cyc(4'b1001, 4'b1001, 1'b1, 4'b0100, 1'b1, 2'd2, "lk_gap1");
    cyc(4'b1001, 4'b1001, 1'b1, 4'b0100, 1'b0, 2'd0, "lk_gap2");
    cyc(4'b1101, 4'b1001, 1'b1, 4'b0100, 1'b0, 2'd0, "lk_b2");
    cyc(4'b1101, 4'b1101, 1'b1, 4'b0100, 1'b1, 2'd2, "lk_b3");
    cyc(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd2, "lk_r3");
    cyc(4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd3, "lk_r0");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, "lk_end");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "lk_idle");

    // Pointer wrap 3 -> 0.
    cyc(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0, "wr_3");
    cyc(4'b1001, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd3, "wr_0");
    cyc(4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd0, "wr_3b");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, "wr_end");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "wr_idle");

    // Fill to capacity, stall, pop once, refill once.
    for (int k = 0; k < 15; k++)
      cyc(4'b0010, 4'b0010, 1'b0, 4'b0010, k > 0, 2'd1, "fill");
    cyc(4'b0010, 4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, "full");
    cyc(4'b1101, 4'b1101, 1'b0, 4'b0000, 1'b1, 2'd1, "stall1");
    cyc(4'b1101, 4'b1101, 1'b0, 4'b0000, 1'b1, 2'd1, "stall2");
    cyc(4'b1101, 4'b1101, 1'b1, 4'b0000, 1'b1, 2'd1, "pop");
    cyc(4'b1101, 4'b1101, 1'b0, 4'b0100, 1'b1, 2'd1, "refill");
    cyc(4'b1101, 4'b1101, 1'b0, 4'b0000, 1'b1, 2'd1, "refull");

    // Reset with the FIFO full.
    in_valid = 4'hF;
    reset    = 1'b0;
    #1;
    chk("rst1.in_ready",  32'(in_ready), 32'(0));
    chk("rst1.out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "rst1_empty");

    // Reset while locked on requester 3 with 5 entries buffered.
    for (int k = 0; k < 5; k++)
      cyc(4'b1000, 4'b0000, 1'b0, 4'b1000, k > 0, 2'd3, "lk5");
    in_valid = 4'b1111;
    in_last  = 4'b0000;
    #1;
    chk("lk5.held_rdy", 32'(in_ready), 32'h8);
    reset = 1'b0;
    #1;
    chk("rst2.in_ready",  32'(in_ready), 32'(0));
    chk("rst2.out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    chk("rst2.out_valid_edge", 32'(out_valid), 32'(0));
    reset = 1'b1;
    cyc(4'b1010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, "rst2_grant");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1, "rst2_out");
    cyc(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, "rst2_idle");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
